// File: rtl/sdram_scheduler.sv
// Shares one SDRAM interface between two round-robin ports and a fixed-priority auto-refresh timer.
// Optional per-source grant/refresh counters are enabled with `define SDRAM_SCHED_STATS_EN.
module sdram_scheduler #(
  parameter int REFRESH_INTERVAL = 374,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET_N,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [23:0] ADDR0,
  input  logic [23:0] ADDR1,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic [15:0] RDATA,
  output logic [1:0]  SD_CMD,
  output logic [1:0]  SD_BANK,
  output logic [12:0] SD_ROW,
  output logic [8:0]  SD_COL,
  output logic [15:0] SD_DIN,
  input  logic        SD_STATUS,
  input  logic [15:0] SD_DREAD,
  output logic        ERR_TIMEOUT
`ifdef SDRAM_SCHED_STATS_EN
  ,
  output logic [15:0] GRANT_CNT0,
  output logic [15:0] GRANT_CNT1,
  output logic [15:0] REFRESH_CNT
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_COMPLETE  = 3'd4;

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_REF  = 2'd3;

  localparam int              RW       = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [RW-1:0]   REF_LAST = RW'(REFRESH_INTERVAL - 1);
  localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          port_q, port_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          wrap;
  logic          pick;
  logic          is_port;

  assign wrap = (ref_cnt_q == REF_LAST);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    ref_cnt_d  = wrap ? '0 : ref_cnt_q + 1'b1;
    ref_pend_d = ref_pend_q | wrap;
    tmo_d      = tmo_q;
    cmd_d      = cmd_q;
    port_d     = port_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    pick       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A wrap in this very cycle already outranks a port request.
        if (ref_pend_q || wrap) begin
          ref_pend_d = 1'b0;
          cmd_d      = CMD_REF;
          state_d    = S_ISSUE;
        end else if (REQ0 || REQ1) begin
          pick    = (REQ0 && REQ1) ? rr_q : REQ1;
          port_d  = pick;
          rr_d    = ~pick;
          cmd_d   = (pick ? WE1 : WE0) ? CMD_WR : CMD_RD;
          addr_d  = pick ? ADDR1 : ADDR0;
          wdata_d = pick ? WDATA1 : WDATA0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (SD_STATUS) begin
          tmo_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!SD_STATUS) begin
          if (cmd_q == CMD_RD) rdata_d = SD_DREAD;
          state_d = S_COMPLETE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      tmo_q      <= '0;
      cmd_q      <= CMD_IDLE;
      port_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode straight from state so the async reset clears them at once.
  assign is_port     = (cmd_q != CMD_REF);
  assign SD_CMD      = (state_q == S_ISSUE) ? cmd_q : CMD_IDLE;
  assign GNT0        = (state_q == S_ISSUE)    && is_port && !port_q;
  assign GNT1        = (state_q == S_ISSUE)    && is_port &&  port_q;
  assign DONE0       = (state_q == S_COMPLETE) && is_port && !port_q;
  assign DONE1       = (state_q == S_COMPLETE) && is_port &&  port_q;
  assign SD_BANK     = addr_q[23:22];
  assign SD_ROW      = addr_q[21:9];
  assign SD_COL      = addr_q[8:0];
  assign SD_DIN      = wdata_q;
  assign RDATA       = rdata_q;
  assign ERR_TIMEOUT = err_q;

`ifdef SDRAM_SCHED_STATS_EN
  logic [15:0] gcnt0_q, gcnt1_q, rcnt_q;

  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      rcnt_q  <= '0;
    end else begin
      if (GNT0 && gcnt0_q != 16'hFFFF) gcnt0_q <= gcnt0_q + 16'd1;
      if (GNT1 && gcnt1_q != 16'hFFFF) gcnt1_q <= gcnt1_q + 16'd1;
      if (SD_CMD == CMD_REF && rcnt_q != 16'hFFFF) rcnt_q <= rcnt_q + 16'd1;
    end
  end

  assign GRANT_CNT0  = gcnt0_q;
  assign GRANT_CNT1  = gcnt1_q;
  assign REFRESH_CNT = rcnt_q;
`endif

endmodule

// File: tb/tb_sdram_scheduler.sv
// Directed bench for sdram_scheduler: vector table for port traffic plus refresh, timeout and reset sequences.
module tb_sdram_scheduler;
  localparam int RI = 24;

  logic        clk;
  logic        RESET_N;
  logic        REQ0, REQ1, WE0, WE1;
  logic [23:0] ADDR0, ADDR1;
  logic [15:0] WDATA0, WDATA1;
  logic        GNT0, GNT1, DONE0, DONE1;
  logic [15:0] RDATA;
  logic [1:0]  SD_CMD, SD_BANK;
  logic [12:0] SD_ROW;
  logic [8:0]  SD_COL;
  logic [15:0] SD_DIN;
  logic        SD_STATUS;
  logic [15:0] SD_DREAD;
  logic        ERR_TIMEOUT;
`ifdef SDRAM_SCHED_STATS_EN
  logic [15:0] GRANT_CNT0, GRANT_CNT1, REFRESH_CNT;
`endif

  sdram_scheduler #(.REFRESH_INTERVAL(RI), .TIMEOUT_CYCLES(255)) dut (
    .CLK_48MHZ(clk), .RESET_N(RESET_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1), .RDATA(RDATA),
    .SD_CMD(SD_CMD), .SD_BANK(SD_BANK), .SD_ROW(SD_ROW), .SD_COL(SD_COL), .SD_DIN(SD_DIN),
    .SD_STATUS(SD_STATUS), .SD_DREAD(SD_DREAD), .ERR_TIMEOUT(ERR_TIMEOUT)
`ifdef SDRAM_SCHED_STATS_EN
    , .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1), .REFRESH_CNT(REFRESH_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (!RESET_N) cyc = 0;
    else cyc = cyc + 1;
  end

  // Interface model: busy one negedge after a command, held hold_len extra cycles, read data = ~addr[15:0].
  logic        model_en;
  int          hold_len;
  int          hold;
  logic        m_rd;
  logic [15:0] m_data;
  always @(negedge clk) begin
    if (!RESET_N) begin
      SD_STATUS = 1'b0;
      hold      = 0;
    end else if (model_en && SD_CMD != 2'd0) begin
      SD_STATUS = 1'b1;
      hold      = hold_len;
      m_rd      = (SD_CMD == 2'd1);
      m_data    = ~{SD_ROW[6:0], SD_COL};
    end else if (hold > 0) begin
      hold = hold - 1;
    end else if (SD_STATUS) begin
      SD_STATUS = 1'b0;
      if (m_rd) SD_DREAD = m_data;
    end
  end

  logic [62:0] outs;
  assign outs = {GNT0, GNT1, DONE0, DONE1, RDATA, SD_CMD, SD_BANK, SD_ROW, SD_COL, SD_DIN, ERR_TIMEOUT};

  int total;
  int bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_pulse(input bit want_done, input int limit, input string nm,
                            output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (want_done ? (DONE0 | DONE1) : (GNT0 | GNT1)) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s: no pulse within %0d cycles", nm, limit);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET_N = 1'b0;
    REQ0    = 1'b0;
    REQ1    = 1'b0;
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
  endtask

  typedef struct {
    logic        r0, r1, we0, we1;
    logic [23:0] a0, a1;
    logic [15:0] d0, d1;
    logic        exp_port;
    logic [1:0]  exp_cmd, exp_bank;
    logic [12:0] exp_row;
    logic [8:0]  exp_col;
    logic [15:0] exp_din, exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  at, g, d;
    bit  ok;
    int  first_ref, last_ref, nref, nstray;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h402A15, 24'h000000, 16'hBEEF, 16'h0000,
                1'b0, 2'd2, 2'd1, 13'h0015, 9'h015, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h812345, 16'h0000, 16'h1111,
                1'b1, 2'd1, 2'd2, 13'h0091, 9'h145, 16'h1111, 16'hDCBA};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 16'hA0A0, 16'hB1B1,
                1'b0, 2'd1, 2'd0, 13'h0000, 9'h100, 16'hA0A0, 16'hFEFF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 16'hA0A0, 16'hB1B1,
                1'b1, 2'd1, 2'd0, 13'h0001, 9'h000, 16'hB1B1, 16'hFDFF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 16'hA0A0, 16'hB1B1,
                1'b0, 2'd1, 2'd0, 13'h0000, 9'h100, 16'hA0A0, 16'hFEFF};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 16'hA0A0, 16'hB1B1,
                1'b1, 2'd1, 2'd0, 13'h0001, 9'h000, 16'hB1B1, 16'hFDFF};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 16'h1234, 16'h0000,
                1'b0, 2'd2, 2'd3, 13'h1FFF, 9'h1FF, 16'h1234, 16'hFDFF};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 24'h000000, 16'h0000, 16'hFFFF,
                1'b1, 2'd2, 2'd0, 13'h0000, 9'h000, 16'hFFFF, 16'hFDFF};

    total = 0; bad = 0;
    RESET_N = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    SD_DREAD = '0; model_en = 1'b1; hold_len = 1;

    // Reset state, then idle refresh cadence with no requesters.
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(outs), 64'd0);
    RESET_N = 1'b1;
    first_ref = -1; last_ref = -1; nref = 0; nstray = 0;
    while (cyc < 3 * RI + 2) begin
      @(negedge clk);
      if (SD_CMD == 2'd3) begin
        if (first_ref < 0) first_ref = cyc;
        last_ref = cyc;
        nref = nref + 1;
      end
      if (GNT0 | GNT1 | DONE0 | DONE1) nstray = nstray + 1;
    end
    chk("ref_first", 64'(first_ref), 64'(RI));
    chk("ref_last", 64'(last_ref), 64'(3 * RI));
    chk("ref_count", 64'(nref), 64'd3);
    chk("ref_no_gnt_done", 64'(nstray), 64'd0);
    $display("refresh-only: first=%0d last=%0d count=%0d", first_ref, last_ref, nref);

    // Refresh wrap lands on the same edge as a new REQ1.
    do_reset();
    while (cyc != RI - 1) @(negedge clk);
    REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 24'h000010;
    @(negedge clk);
    chk("coinc_refresh_cmd", 64'(SD_CMD), 64'd3);
    chk("coinc_no_gnt1", 64'(GNT1), 64'd0);
    wait_pulse(1'b0, 20, "coinc_gnt", at, ok);
    if (ok) begin
      chk("coinc_gnt_cycle", 64'(at), 64'(RI + 5));
      chk("coinc_gnt1", 64'(GNT1), 64'd1);
      chk("coinc_read_cmd", 64'(SD_CMD), 64'd1);
      REQ1 = 1'b0;
      wait_pulse(1'b1, 20, "coinc_done", at, ok);
      if (ok) begin
        chk("coinc_done1", 64'(DONE1), 64'd1);
        chk("coinc_rdata", 64'(RDATA), 64'hFFEF);
      end
    end
    REQ1 = 1'b0;
    $display("coincident refresh/REQ1: rdata=%h", RDATA);

    // Vector table: single requesters, continuous round-robin, address boundaries.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      REQ0 = vecs[i].r0;   REQ1 = vecs[i].r1;
      WE0 = vecs[i].we0;   WE1 = vecs[i].we1;
      ADDR0 = vecs[i].a0;  ADDR1 = vecs[i].a1;
      WDATA0 = vecs[i].d0; WDATA1 = vecs[i].d1;
      wait_pulse(1'b0, 40, $sformatf("v%0d_gnt", i), at, ok);
      if (ok) begin
        chk($sformatf("v%0d_port", i), 64'(GNT1), 64'(vecs[i].exp_port));
        chk($sformatf("v%0d_onehot", i), 64'(GNT0 & GNT1), 64'd0);
        chk($sformatf("v%0d_cmd", i), 64'(SD_CMD), 64'(vecs[i].exp_cmd));
        chk($sformatf("v%0d_bank", i), 64'(SD_BANK), 64'(vecs[i].exp_bank));
        chk($sformatf("v%0d_row", i), 64'(SD_ROW), 64'(vecs[i].exp_row));
        chk($sformatf("v%0d_col", i), 64'(SD_COL), 64'(vecs[i].exp_col));
        chk($sformatf("v%0d_din", i), 64'(SD_DIN), 64'(vecs[i].exp_din));
        if (GNT0) REQ0 = 1'b0;
        if (GNT1) REQ1 = 1'b0;
        wait_pulse(1'b1, 40, $sformatf("v%0d_done", i), at, ok);
        if (ok) begin
          chk($sformatf("v%0d_done_port", i), 64'(DONE1), 64'(vecs[i].exp_port));
          chk($sformatf("v%0d_rdata", i), 64'(RDATA), 64'(vecs[i].exp_rdata));
        end
      end
      $display("vec %0d: port=%0d cmd=%0d bank=%0d row=%h col=%h din=%h rdata=%h",
               i, GNT1 | DONE1, vecs[i].exp_cmd, SD_BANK, SD_ROW, SD_COL, SD_DIN, RDATA);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;

    // Interface never goes busy: watchdog aborts the read.
    do_reset();
    model_en = 1'b0;
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 24'h000055;
    g = -1; d = -1;
    wait_pulse(1'b0, 10, "tmo_gnt", g, ok);
    REQ0 = 1'b0;
    if (ok) begin
      wait_pulse(1'b1, 300, "tmo_done", d, ok);
      if (ok) begin
        chk("tmo_latency", 64'(d - g), 64'd256);
        chk("tmo_done0", 64'(DONE0), 64'd1);
        chk("tmo_err", 64'(ERR_TIMEOUT), 64'd1);
        chk("tmo_rdata", 64'(RDATA), 64'd0);
      end
    end
    repeat (20) @(negedge clk);
    chk("tmo_err_sticky", 64'(ERR_TIMEOUT), 64'd1);
    $display("timeout: gnt=%0d done=%0d err=%0d", g, d, ERR_TIMEOUT);

    // Reset asserted while waiting for the interface to go idle.
    model_en = 1'b1;
    hold_len = 20;
    do_reset();
    chk("err_cleared", 64'(ERR_TIMEOUT), 64'd0);
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 24'h402A15; WDATA0 = 16'hBEEF;
    wait_pulse(1'b0, 10, "mid_gnt", at, ok);
    REQ0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_pre_bank", 64'(SD_BANK), 64'd1);
    @(posedge clk);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_reset_outs", 64'(outs), 64'd0);
`ifdef SDRAM_SCHED_STATS_EN
    chk("mid_reset_cnts", 64'({GRANT_CNT0, GRANT_CNT1, REFRESH_CNT}), 64'd0);
`endif
    $display("reset in wait_done: outs=%h", outs);
    @(negedge clk);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
